imgproc_ctrl: RTL and testbench

Frame-level sequencer for the Sobel edge datapath. Sits between the CCD capture interface and the 3x3 convolution pipeline. Tracks pixel coordinates and sequences line-buffer priming (FILL) and steady-state (RUN). Latches the horizontal/vertical kernel select once per frame, flags pixels whose 3x3 window is complete, and reports frame completion and frame-size errors.

---
 rtl/imgproc_ctrl_if.sv | 29 ++
 rtl/imgproc_ctrl.sv | 109 ++++++++++
 tb/tb_imgproc_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/imgproc_ctrl_if.sv
// Bus between the CCD capture block, the Sobel frame sequencer and the convolution datapath.
// The master drives frame/pixel valid and the kernel request; the slave (imgproc_ctrl) returns the rest.
interface imgproc_ctrl_if;
    logic        iFVAL;
    logic        iDVAL;
    logic        iSW;
    logic        oMODE;
    logic        oPIX_VAL;
    logic [15:0] oX_Cont;
    logic [15:0] oY_Cont;
    logic        oWIN_VALID;
    logic [1:0]  oSTATE;
    logic        oFRAME_DONE;
    logic        oSHORT;
    logic        oOVF;
    logic [15:0] oFRAME_CNT;

    modport master (
        output iFVAL, iDVAL, iSW,
        input  oMODE, oPIX_VAL, oX_Cont, oY_Cont, oWIN_VALID,
        input  oSTATE, oFRAME_DONE, oSHORT, oOVF, oFRAME_CNT
    );

    modport slave (
        input  iFVAL, iDVAL, iSW,
        output oMODE, oPIX_VAL, oX_Cont, oY_Cont, oWIN_VALID,
        output oSTATE, oFRAME_DONE, oSHORT, oOVF, oFRAME_CNT
    );
endinterface

// File: rtl/imgproc_ctrl.sv
// Frame-level sequencer for the Sobel edge datapath: tracks pixel coordinates, primes the
// line buffers (FILL), runs steady state (RUN), and reports frame completion and size errors.
module imgproc_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic          iCLK,
    input  logic          iRST,
    imgproc_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } stateT;

    localparam logic [15:0] LAST_X = 16'(IMG_W - 1);
    localparam logic [15:0] LAST_Y = 16'(IMG_H - 1);

    stateT       state;
    logic        fvalQ;
    logic [15:0] nx;
    logic [15:0] ny;
    logic        frameFull;

    assign bus.oSTATE = state;

    // fvalQ resets high so a frame already running at reset release is not mistaken for a new one.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state           <= IDLE;
            fvalQ           <= 1'b1;
            nx              <= 16'd0;
            ny              <= 16'd0;
            frameFull       <= 1'b0;
            bus.oMODE       <= 1'b0;
            bus.oPIX_VAL    <= 1'b0;
            bus.oX_Cont     <= 16'd0;
            bus.oY_Cont     <= 16'd0;
            bus.oWIN_VALID  <= 1'b0;
            bus.oFRAME_DONE <= 1'b0;
            bus.oSHORT      <= 1'b0;
            bus.oOVF        <= 1'b0;
            bus.oFRAME_CNT  <= 16'd0;
        end else begin
            fvalQ           <= bus.iFVAL;
            bus.oPIX_VAL    <= 1'b0;
            bus.oWIN_VALID  <= 1'b0;
            bus.oFRAME_DONE <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.iFVAL && !fvalQ) begin
                        state      <= FILL;
                        bus.oMODE  <= bus.iSW;
                        nx         <= 16'd0;
                        ny         <= 16'd0;
                        frameFull  <= 1'b0;
                        bus.oSHORT <= 1'b0;
                        bus.oOVF   <= 1'b0;
                    end
                end

                FILL, RUN: begin
                    if (!bus.iFVAL) begin
                        state           <= DONE;
                        bus.oFRAME_DONE <= 1'b1;
                        bus.oFRAME_CNT  <= bus.oFRAME_CNT + 16'd1;
                        bus.oSHORT      <= !frameFull;
                    end else if (bus.iDVAL) begin
                        if (frameFull) begin
                            bus.oOVF <= 1'b1;
                        end else begin
                            bus.oPIX_VAL   <= 1'b1;
                            bus.oX_Cont    <= nx;
                            bus.oY_Cont    <= ny;
                            bus.oWIN_VALID <= (nx >= 16'd2) && (ny >= 16'd2);
                            // Two complete lines are buffered once the last pixel of row 1 arrives.
                            if (state == FILL && nx == LAST_X && ny == 16'd1) begin
                                state <= RUN;
                            end
                            if (nx == LAST_X) begin
                                nx <= 16'd0;
                                if (ny == LAST_Y) begin
                                    frameFull <= 1'b1;
                                end else begin
                                    ny <= ny + 16'd1;
                                end
                            end else begin
                                nx <= nx + 16'd1;
                            end
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imgproc_ctrl.sv
// Self-checking bench for imgproc_ctrl (4x3 frames): directed scenarios followed by random
// frame/pixel traffic, all checked against a pixel-count based reference model.
module tb_imgproc_ctrl;

    localparam int W = 4;
    localparam int H = 3;

    logic iCLK;
    logic iRST;
    int   testCnt;
    int   failCnt;

    // Reference model: a frame is just a count of accepted pixels plus a few flags.
    bit capturing;
    bit doneCycle;
    bit prevF;
    bit mMode;
    bit mShort;
    bit mOvf;
    bit mPix;
    bit mWin;
    bit mDone;
    int accepted;
    int mX;
    int mY;
    int mCnt;

    imgproc_ctrl_if bus ();

    imgproc_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    function automatic int expState();
        if (doneCycle) return 3;
        if (!capturing) return 0;
        return (accepted >= 2 * W) ? 2 : 1;
    endfunction

    task automatic modelReset();
        capturing = 0; doneCycle = 0; prevF = 1;
        mMode = 0; mShort = 0; mOvf = 0; mPix = 0; mWin = 0; mDone = 0;
        accepted = 0; mX = 0; mY = 0; mCnt = 0;
    endtask

    task automatic modelEdge(input bit f, input bit d, input bit s);
        mPix = 0; mWin = 0; mDone = 0;
        if (doneCycle) begin
            doneCycle = 0;
        end else if (!capturing) begin
            if (f && !prevF) begin
                capturing = 1; accepted = 0; mMode = s; mShort = 0; mOvf = 0;
            end
        end else if (!f) begin
            capturing = 0; doneCycle = 1; mDone = 1; mCnt++;
            mShort = (accepted < W * H);
        end else if (d) begin
            if (accepted == W * H) begin
                mOvf = 1;
            end else begin
                mPix = 1;
                mX = accepted % W;
                mY = accepted / W;
                mWin = (mX >= 2) && (mY >= 2);
                accepted++;
            end
        end
        prevF = f;
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput();
        cmp("oSTATE", 32'(bus.oSTATE), 32'(expState()));
        cmp("oPIX_VAL", 32'(bus.oPIX_VAL), 32'(mPix));
        cmp("oX_Cont", 32'(bus.oX_Cont), 32'(mX));
        cmp("oY_Cont", 32'(bus.oY_Cont), 32'(mY));
        cmp("oWIN_VALID", 32'(bus.oWIN_VALID), 32'(mWin));
        cmp("oMODE", 32'(bus.oMODE), 32'(mMode));
        cmp("oFRAME_DONE", 32'(bus.oFRAME_DONE), 32'(mDone));
        cmp("oSHORT", 32'(bus.oSHORT), 32'(mShort));
        cmp("oOVF", 32'(bus.oOVF), 32'(mOvf));
        cmp("oFRAME_CNT", 32'(bus.oFRAME_CNT), 32'(mCnt & 16'hFFFF));
    endtask

    task automatic applyStimulus(input bit f, input bit d, input bit s);
        bus.iFVAL = f;
        bus.iDVAL = d;
        bus.iSW   = s;
        modelEdge(f, d, s);
        @(posedge iCLK);
        #1;
        checkOutput();
    endtask

    // One frame of nDval pixel pulses; gaps inserts idle cycles, iSW flips after frame start.
    task automatic runFrame(input int nDval, input bit sw, input bit gaps);
        applyStimulus(1'b0, 1'b0, sw);
        applyStimulus(1'b1, 1'b0, sw);
        for (int i = 0; i < nDval; i++) begin
            if (gaps) applyStimulus(1'b1, 1'b0, ~sw);
            applyStimulus(1'b1, 1'b1, ~sw);
        end
        applyStimulus(1'b0, 1'b0, sw);
        applyStimulus(1'b0, 1'b1, sw);
        applyStimulus(1'b0, 1'b1, sw);
        applyStimulus(1'b0, 1'b0, sw);
    endtask

    initial begin
        testCnt = 0;
        failCnt = 0;
        bus.iFVAL = 1'b0;
        bus.iDVAL = 1'b0;
        bus.iSW   = 1'b0;
        iRST = 1'b0;
        modelReset();
        #12;
        checkOutput();
        iRST = 1'b1;

        $display("[TB] nominal frame");
        runFrame(12, 1'b0, 1'b0);

        $display("[TB] mode latch with iSW=1, then iSW=0");
        runFrame(12, 1'b1, 1'b0);
        runFrame(12, 1'b0, 1'b0);

        $display("[TB] short frame, then restart");
        runFrame(7, 1'b0, 1'b0);
        runFrame(12, 1'b0, 1'b0);

        $display("[TB] overflow");
        runFrame(14, 1'b1, 1'b0);
        runFrame(3, 1'b0, 1'b0);

        $display("[TB] stalls");
        runFrame(12, 1'b0, 1'b1);

        $display("[TB] frame start during DONE is skipped");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        iRST = 1'b0;
        modelReset();
        #1;
        checkOutput();
        #2;
        iRST = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        runFrame(12, 1'b1, 1'b0);

        $display("[TB] random traffic");
        begin
            bit f;
            f = 1'b0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 15) == 0) f = ~f;
                applyStimulus(f, ($urandom_range(0, 3) != 0), 1'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
